// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants and receiver state encoding.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam int OVERSAMPLE = 16;
   localparam logic [3:0] SMP_MID = 4'd7;
   localparam logic [3:0] SMP_LAST = 4'd15;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         meta_q <= RST_VAL;
         q_o <= RST_VAL;
      end else begin
         meta_q <= d_i;
         q_o <= meta_q;
      end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver with sticky ready and overrun flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_50m,
   input  logic                 rst,
   input  logic                 clken,
   input  logic                 rx,
   input  logic                 rdy_clr,
   output logic [DATA_BITS-1:0] data,
   output logic                 rdy,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err,
   output logic                 rx_busy
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state_q, state_d;
   logic rx_s;
   logic [SW-1:0] smp_q, smp_d;
   logic [BW-1:0] bitpos_q, bitpos_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic stop_smp, land;
   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk(clk_50m),
      .rst(rst),
      .d_i(rx),
      .q_o(rx_s)
   );
   always_comb begin
      state_d = state_q;
      smp_d = clken ? smp_q + 1'b1 : smp_q;
      bitpos_d = bitpos_q;
      shift_d = shift_q;
      stop_smp = 1'b0;
      case (state_q)
         IDLE: begin
            smp_d = '0;
            bitpos_d = '0;
            state_d = (clken && !rx_s) ? START : IDLE;
         end
         START:
            if (clken && smp_q == SMP_MID) begin
               smp_d = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         DATA:
            if (clken && smp_q == SMP_LAST) begin
               shift_d[bitpos_q] = rx_s;
               bitpos_d = bitpos_q + 1'b1;
               state_d = (bitpos_q == LAST_BIT) ? AFTER_DATA : DATA;
            end
`ifdef UART_RX_PARITY_EN
         PARITY:
            if (clken && smp_q == SMP_LAST) state_d = STOP;
`endif
         STOP:
            if (clken && smp_q == SMP_LAST) begin
               stop_smp = 1'b1;
               state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase
   end
   assign land = stop_smp & rx_s;
   assign rx_busy = state_q != IDLE;
   always_ff @(posedge clk_50m or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         smp_q <= '0;
         bitpos_q <= '0;
         shift_q <= '0;
         data <= '0;
         rdy <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state_q <= state_d;
         smp_q <= smp_d;
         bitpos_q <= bitpos_d;
         shift_q <= shift_d;
         if (land) data <= shift_q;
         if (stop_smp) frame_err <= ~rx_s;
         // a landing byte beats a simultaneous clear, and that clear still suppresses overrun
         rdy <= land | (rdy & ~rdy_clr);
         overrun <= ~rdy_clr & (overrun | (land & rdy));
      end
`ifdef UART_RX_PARITY_EN
   logic par_q;
   always_ff @(posedge clk_50m or posedge rst)
      if (rst) begin
         par_q <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (clken && state_q == PARITY && smp_q == SMP_LAST) par_q <= rx_s;
         if (stop_smp) parity_err <= ^shift_q ^ par_q;
      end
`else
   assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frame-level check of uart_receiver against a byte/flag model.
`timescale 1ns/1ps
module tb_uart_receiver;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int LAT = PAR ? 168 : 152;
   logic clk_50m = 1'b0;
   logic rst = 1'b1;
   logic clken = 1'b0;
   logic rx = 1'b1;
   logic rdy_clr = 1'b0;
   logic [7:0] data;
   logic rdy, frame_err, overrun, parity_err, rx_busy;
   int n_cmp = 0;
   int n_err = 0;
   int tick_cnt = 0;
   int t_rise = -1000;
   int lat = -1;
   logic busy_prev = 1'b0;
   logic clr_arm = 1'b0;
   logic dense = 1'b1;
   logic [7:0] m_data = 8'h00;
   logic m_rdy = 1'b0;
   logic m_ferr = 1'b0;
   logic m_ovr = 1'b0;
   logic m_perr = 1'b0;
   uart_receiver #(.DATA_BITS(8)) dut (
      .clk_50m(clk_50m),
      .rst(rst),
      .clken(clken),
      .rx(rx),
      .rdy_clr(rdy_clr),
      .data(data),
      .rdy(rdy),
      .frame_err(frame_err),
      .overrun(overrun),
      .parity_err(parity_err),
      .rx_busy(rx_busy)
   );
   always #5 clk_50m = ~clk_50m;
   initial forever begin
      @(negedge clk_50m);
      clken = dense ? 1'b1 : ($urandom_range(0, 2) == 0);
   end
   always @(posedge clk_50m) if (clken) tick_cnt <= tick_cnt + 1;
   initial begin
      #800000;
      $display("FAIL watchdog: got no finish, expected finish before 800us");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_outs(input string tag);
      check({tag, "_data"}, 32'(data), 32'(m_data));
      check({tag, "_rdy"}, 32'(rdy), 32'(m_rdy));
      check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
      check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
      check({tag, "_perr"}, 32'(parity_err), 32'(m_perr));
   endtask
   // hold rx at b for n clken ticks while timing rx_busy edges in ticks
   task automatic hold(input logic b, input int n);
      int k;
      k = 0;
      rx = b;
      while (k < n) begin
         @(posedge clk_50m);
         #1;
         if (clken) k++;
         if (rx_busy && !busy_prev) t_rise = tick_cnt;
         if (!rx_busy && busy_prev && lat < 0) lat = tick_cnt - t_rise;
         busy_prev = rx_busy;
         if (clr_arm) rdy_clr = (tick_cnt == t_rise + LAT - 1);
      end
   endtask
   task automatic pulse_clr();
      @(posedge clk_50m);
      #1;
      rdy_clr = 1'b1;
      @(posedge clk_50m);
      #1;
      rdy_clr = 1'b0;
      m_rdy = 1'b0;
      m_ovr = 1'b0;
   endtask
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic pf, input logic clr_co);
      t_rise = -1000;
      lat = -1;
      clr_arm = clr_co;
      hold(1'b0, 16);
      for (int i = 0; i < 8; i++) hold(b[i], 16);
      if (PAR) hold(^b ^ pf, 16);
      hold(stop, 13);
      clr_arm = 1'b0;
      rdy_clr = 1'b0;
      if (stop) begin
         m_ovr = clr_co ? 1'b0 : (m_ovr | m_rdy);
         m_rdy = 1'b1;
         m_data = b;
         m_ferr = 1'b0;
      end else begin
         m_ferr = 1'b1;
         if (clr_co) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
         end
      end
      m_perr = PAR ? pf : 1'b0;
      check("lat", 32'(lat), 32'(LAT));
      check_outs("frame");
      hold(1'b1, 3);
      if (!stop) hold(1'b1, 20);
   endtask
   initial begin
      logic [7:0] b;
      logic stop, pf;
      repeat (3) @(posedge clk_50m);
      #1;
      check("rst_busy", 32'(rx_busy), 0);
      check_outs("rst");
      rst = 1'b0;
      hold(1'b1, 20);
      check_outs("post_rst");
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      check("x55_data", 32'(data), 32'h55);
      t_rise = -1000;
      lat = -1;
      hold(1'b0, 4);
      hold(1'b1, 24);
      check("glitch_lat", 32'(lat), 8);
      check("glitch_busy", 32'(rx_busy), 0);
      check_outs("glitch");
      pulse_clr();
      send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
      check("a3_ferr", 32'(frame_err), 1);
      check("a3_data", 32'(data), 32'h55);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      check("3c_ferr", 32'(frame_err), 0);
      pulse_clr();
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      check("ovr_set", 32'(overrun), 1);
      send_frame(8'h33, 1'b1, 1'b0, 1'b1);
      check("ovr_coincide_rdy", 32'(rdy), 1);
      check("ovr_coincide_ovr", 32'(overrun), 0);
      t_rise = -1000;
      lat = -1;
      for (int i = 0; i < 5; i++) hold(1'b0, 16);
      hold(1'b0, 8);
      rst = 1'b1;
      #1;
      m_data = 8'h00;
      m_rdy = 1'b0;
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      m_perr = 1'b0;
      check("midrst_busy", 32'(rx_busy), 0);
      check_outs("midrst");
      rx = 1'b1;
      busy_prev = 1'b0;
      repeat (3) @(posedge clk_50m);
      #1;
      rst = 1'b0;
      hold(1'b1, 20);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
      if (PAR) begin
         send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
         check("par_bad", 32'(parity_err), 1);
         send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
         check("par_good", 32'(parity_err), 0);
      end
      for (int i = 0; i < 24; i++) begin
         dense = ($urandom_range(0, 3) == 0);
         b = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         pf = 1'($urandom_range(0, 1));
         send_frame(b, stop, pf, 1'b0);
         if ($urandom_range(0, 2) == 0) pulse_clr();
         hold(1'b1, $urandom_range(0, 6));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
